// File: rtl/hilf_elem_sched_if.sv
// hilf_elem_sched_if: count handshake between the code source and the scheduler.
// Ports: code (requested element count), code_vld (count valid), code_rdy (scheduler idle).
interface hilf_elem_sched_if #(
   parameter int CW = 5
);
   logic [CW-1:0] code;
   logic          code_vld;
   logic          code_rdy;

   modport master (
      output code,
      output code_vld,
      input  code_rdy
   );

   modport slave (
      input  code,
      input  code_vld,
      output code_rdy
   );
endinterface

// File: rtl/hilf_elem_sched.sv
// hilf_elem_sched: sequential element selector for the 18-element 1st-order ISI shaping loop filter.
// Picks K elements lowest-priority first, then drives sel/st and a one-cycle filter enable.
// Ports: clk, rstn (async, active-low), cif (slave: code/code_vld/code_rdy),
//   sfi_bus (filter SFI outputs, N*W), sel/st (registered N-bit vectors),
//   flt_en/done (FIRE pulse), sat_err (count clamped).
// Option: define HILF_SEL_ROTATE_EN for round-robin tie-breaking (pointer rp).
module hilf_elem_sched #(
   parameter int N  = 18,
   parameter int W  = 4,
   parameter int CW = 5
) (
   input  logic                 clk,
   input  logic                 rstn,
   hilf_elem_sched_if.slave     cif,
   input  logic [N*W-1:0]       sfi_bus,
   output logic [N-1:0]         sel,
   output logic [N-1:0]         st,
   output logic                 flt_en,
   output logic                 done,
   output logic                 sat_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PICK  = 2'd1;
   localparam logic [1:0] S_APPLY = 2'd2;
   localparam logic [1:0] S_FIRE  = 2'd3;

   localparam logic [CW-1:0] NK = CW'(N);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] kl_q, kl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  mask_q, mask_d;
   logic [N-1:0]  sel_q, sel_d;
   logic [N-1:0]  st_q, st_d;
   logic          sat_q, sat_d;
   logic [W-1:0]  p_q [N];

`ifdef HILF_SEL_ROTATE_EN
   logic [4:0]    rp_q;
`endif

   // Minimum search over unmasked elements. Strict '<' keeps the first
   // candidate in scan order, so the scan start sets the tie-break.
   logic [4:0]    win_idx;
   logic [W-1:0]  win_val;
   logic          found;
   logic [4:0]    idx;
`ifdef HILF_SEL_ROTATE_EN
   logic [5:0]    idx6;
`endif

   always_comb begin
      win_idx = '0;
      win_val = '1;
      found   = 1'b0;
      idx     = '0;
`ifdef HILF_SEL_ROTATE_EN
      idx6    = '0;
`endif
      for (int j = 0; j < N; j++) begin
`ifdef HILF_SEL_ROTATE_EN
         idx6 = {1'b0, rp_q} + 6'(j);
         if (idx6 >= 6'(N)) idx6 = idx6 - 6'(N);
         idx  = idx6[4:0];
`else
         idx  = 5'(j);
`endif
         if (!mask_q[idx] &&
             (!found || p_q[idx] < win_val)) begin
            found   = 1'b1;
            win_val = p_q[idx];
            win_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      kl_d    = kl_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      sel_d   = sel_q;
      st_d    = st_q;
      sat_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cif.code_vld) begin
               sat_d  = cif.code > NK;
               kl_d   = sat_d ? NK : cif.code;
               cnt_d  = '0;
               mask_d = '0;
               state_d = (kl_d == '0) ? S_APPLY : S_PICK;
            end
         end
         S_PICK: begin
            mask_d[win_idx] = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == kl_q) state_d = S_APPLY;
         end
         S_APPLY: begin
            sel_d   = mask_q;
            st_d    = mask_q & ~sel_q;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         kl_q    <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         sel_q   <= '0;
         st_q    <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kl_q    <= kl_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         sel_q   <= sel_d;
         st_q    <= st_d;
         sat_q   <= sat_d;
      end
   end

   // The filter latches its FI on this same edge, so P tracks its state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) p_q[i] <= '0;
      end else if (state_q == S_FIRE) begin
         for (int i = 0; i < N; i++) p_q[i] <= sfi_bus[i*W +: W];
      end
   end

`ifdef HILF_SEL_ROTATE_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rp_q <= '0;
      end else if (state_q == S_FIRE) begin
         rp_q <= (rp_q == 5'(N-1)) ? '0 : rp_q + 1'b1;
      end
   end
`endif

   assign cif.code_rdy = (state_q == S_IDLE);
   assign flt_en       = (state_q == S_FIRE);
   assign done         = (state_q == S_FIRE);
   assign sel          = sel_q;
   assign st           = st_q;
   assign sat_err      = sat_q;

endmodule

// File: doc/hilf_elem_sched.md
Name: hilf_elem_sched

Overview:
- Sequential element-selection scheduler for the 18-element, 1st-order ISI shaping loop filter in the DAC digital path.
- Per input sample it accepts a thermometer count K and picks K unit elements, lowest shaped-priority first, using the filter's SFI outputs from the previous sample.
- It drives the element vector to the analog DAC and the up-transition vector ST to the filter.
- It generates the filter's one-cycle clk_en and captures the updated SFI values as the next sample's priorities.

Parameters:
- N, 18, number of unit elements. Fixed by the filter; the scheduler supports only 18.
- W, 4, width of each SFI priority value.
- CW, 5, width of the input count.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- code  input  CW  requested element count K, 0..N
- code_vld  input  1  count valid
- code_rdy  output  1  scheduler idle, count accepted on vld&rdy
- sfi_bus  input  N*W  filter SFI outputs; element i is at bits [i*W+W-1 : i*W]
- sel  output  N  registered element-on vector to the DAC
- st  output  N  registered up-transition vector to the filter's ST input
- flt_en  output  1  one-cycle enable to the filter's clk_en input
- done  output  1  one-cycle pulse, coincident with flt_en
- sat_err  output  1  one-cycle pulse when the accepted code exceeds N

Behaviour:
- Reset values: sel=0, st=0, flt_en=0, done=0, sat_err=0, code_rdy=1, state=IDLE.
- Reset also clears the priority registers P[0..17], the pick mask and the pick counter.
- States: IDLE -> PICK -> APPLY -> FIRE -> IDLE.
- IDLE:
  - code_rdy=1.
  - On code_vld=1, latch Kl = min(code, N) and clear the mask and counter.
  - If code>N, sat_err pulses in the following cycle.
  - If Kl=0, go to APPLY; otherwise go to PICK.
- PICK:
  - code_rdy=0.
  - Each cycle, pick the unmasked index i with minimum P[i]; ties go to the lowest index.
  - Set mask[i] and increment the counter.
  - After Kl picks, go to APPLY. Exactly Kl cycles are spent in PICK.
- APPLY:
  - At the end of the cycle, sel<=mask and st<=mask & ~sel, where sel is the previous sample's vector.
  - Go to FIRE.
- FIRE:
  - flt_en=1 and done=1, combinationally decoded from the state.
  - At the end of the cycle, P[i]<=sfi_bus[i]. The filter registers its FI on the same edge, so P equals the filter's new internal state.
  - Go to IDLE.
- Latency: with the accept edge as cycle 0, the PICK cycles are 1..Kl, APPLY is Kl+1, and FIRE is Kl+2.
  - New sel/st are valid from cycle Kl+2 and held until the next APPLY.
  - code_rdy returns high at cycle Kl+3.
- code_vld while code_rdy=0 is ignored. Upstream must hold the count until it is accepted.
- sfi_bus is sampled only in FIRE. Its value in every other cycle is don't-care.
- popcount(sel) always equals Kl, and st is always a subset of sel.
- Arithmetic:
  - P values are unsigned W-bit.
  - The comparator is unsigned.
  - The counter is CW bits and never exceeds N.
- Reset asserted mid-operation returns everything to reset values immediately, and no flt_en is issued for the aborted sample.

Optional Feature:
- Macro: HILF_SEL_ROTATE_EN.
- When defined:
  - Ties in PICK are broken by a round-robin pointer rp instead of by lowest index.
  - The winner is the first tied index at or above rp, wrapping 17->0.
  - rp resets to 0 and advances by 1 (mod 18) on each FIRE.
- When undefined: rp does not exist, and lowest-index tie-break applies.

Test Plan:
- Reset, then code=5 with all P=0 (vld at cycle 0) -> flt_en and done high only in cycle 7, sel=0x0001F, st=0x0001F; code_rdy=0 in cycles 1-7 and 1 in cycle 8.
- Then drive sfi_bus with elements 0..4=1 and others=0 during FIRE, and send code=3 -> sel=0x000E0 and st=0x000E0. With rotate enabled and rp=1 the result is identical.
- code=0 -> no PICK cycles, flt_en in cycle 2, sel=0, st=0.
- code=25 -> sat_err pulses once, Kl=18, sel=0x3FFFF, flt_en in cycle 20.
- rstn low during cycle 3 of a code=10 pick -> all outputs zero, no flt_en; code_rdy=1 after release, and the next code=2 with P=0 gives sel=0x00003.
- code_vld held high continuously with code=1 -> accepted every 4 cycles; with P=0 and no feedback, sel stays at 0x00001 and st is 0x00001 on the first sample and 0 thereafter.
